// File: rtl/mopshub_uart_pkg.sv
// Shared types for the uplink UART packer: buffered frame layout, packet
// length, packer FSM states and the packet byte selector.
package mopshub_uart_pkg;

  typedef struct packed {
    logic [4:0]  bus;
    logic [75:0] data;
  } uplink_frame_t;

  localparam int unsigned PKT_BYTES     = 13;
  localparam logic [3:0]  LAST_BYTE_IDX = 4'(PKT_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} pack_state_t;

  // Byte idx of the packet for frame f; idx 12 carries the running checksum.
  function automatic logic [7:0] pkt_byte(input uplink_frame_t f,
                                          input logic [3:0]    idx,
                                          input logic [7:0]    csum,
                                          input logic [7:0]    sync);
    logic [3:0] rev;
    rev = 4'd11 - idx;
    case (idx)
      4'd0:    pkt_byte = sync;
      4'd1:    pkt_byte = {3'b000, f.bus};
      4'd2:    pkt_byte = {4'b0000, f.data[75:72]};
      4'd12:   pkt_byte = csum;
      default: pkt_byte = 8'(f.data >> {rev, 3'b000});
    endcase
  endfunction

endpackage

// File: rtl/uplink_frame_fifo.sv
// Synchronous FIFO of uplink frames; extra pointer MSB separates full from
// empty. Push while full and pop while empty are ignored.
module uplink_frame_fifo
  import mopshub_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_40_m,
  input  logic          rst,
  input  logic          push,
  input  uplink_frame_t push_data,
  input  logic          pop,
  output uplink_frame_t head,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  uplink_frame_t mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_40_m) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uplink_uart_packer.sv
// Buffers received uplink CAN frames and streams each one to the UART as a
// 13-byte packet: sync, bus, payload MSB first, XOR checksum of bytes 1..11.
//
// state | meaning
// IDLE  | waiting for a buffered frame
// LOAD  | pop head frame into shadow, clear checksum and byte index
// SEND  | present byte[idx], pulse tx_uart_dv, arm handshake timer
// WAIT  | wait for tx_uart_done, or abandon packet on timer expiry
// DONE  | count the completed packet and release busy
module uplink_uart_packer
  import mopshub_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter logic [15:0] DONE_TIMEOUT = 16'd8000
) (
  input  logic        clk_40_m,
  input  logic        rst,
  input  logic        frame_dv,
  input  logic [75:0] frame_data,
  input  logic [4:0]  frame_bus,
  output logic [7:0]  tx_uart_data,
  output logic        tx_uart_dv,
  input  logic        tx_uart_done,
  output logic        busy,
  output logic        fifo_full,
  output logic [7:0]  drop_cnt,
  output logic [15:0] pkt_cnt,
  output logic        timeout_err
);

  uplink_frame_t in_frame, head, shadow_q, shadow_d;
  logic          fifo_empty, fifo_pop;
  pack_state_t   state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          busy_q, busy_d;
  logic [7:0]    drop_q, drop_d;
  logic [15:0]   pkt_q, pkt_d;
  logic          terr_q, terr_d;

  assign in_frame.bus  = frame_bus;
  assign in_frame.data = frame_data;
  assign fifo_pop      = (state_q == LOAD);

  uplink_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_40_m  (clk_40_m),
    .rst       (rst),
    .push      (frame_dv),
    .push_data (in_frame),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    busy_d   = busy_q;
    drop_d   = drop_q;
    pkt_d    = pkt_q;
    terr_d   = terr_q;

    // Full is the pre-pop flag, so a frame arriving during a pop still drops.
    if (frame_dv && fifo_full && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        shadow_d = head;
        csum_d   = 8'h00;
        idx_d    = 4'd0;
        busy_d   = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        data_d = pkt_byte(shadow_q, idx_q, csum_q, SYNC_BYTE);
        dv_d   = 1'b1;
        if (idx_q != 4'd0 && idx_q != LAST_BYTE_IDX) csum_d = csum_q ^ data_d;
        tmo_d   = DONE_TIMEOUT;
        state_d = WAIT;
      end
      WAIT: begin
        // dv_q is still high in the first WAIT cycle; a done there is too early.
        if (tx_uart_done && !dv_q) begin
          if (idx_q == LAST_BYTE_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end else if (tmo_q <= 16'd1) begin
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      DONE: begin
        pkt_d   = pkt_q + 16'd1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= '0;
      pkt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      pkt_q    <= pkt_d;
      terr_q   <= terr_d;
    end
  end

  assign tx_uart_data = data_q;
  assign tx_uart_dv   = dv_q;
  assign busy         = busy_q;
  assign drop_cnt     = drop_q;
  assign pkt_cnt      = pkt_q;
  assign timeout_err  = terr_q;

endmodule
